// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic engines.
// Latency: none (package only).
// Backpressure: not applicable.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width for an operand of w bits; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done operand and result bundle between the controlling FSM and a serial subtractor.
// Latency: none (wires only).
// Backpressure: none; start is only honoured while the engine is idle.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
// Latency: combinational.
// Backpressure: not applicable.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a single subtractor cell.
// Latency: done pulses in the cycle after edge k+WIDTH for a start accepted at edge k.
// Backpressure: start ignored unless idle; SERIAL_SUB_SIGNED_OVF_EN adds a signed overflow flag.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave sub
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             brw_r;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             cell_d;
    logic             cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw_r),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign sub.busy   = busy_r;
    assign sub.done   = done_r;
    assign sub.diff   = diff_r;
    assign sub.borrow = borrow_r;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_r;

    assign sub.ovf = ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && sub.start) begin
            a_msb <= sub.a[WIDTH-1];
            b_msb <= sub.b[WIDTH-1];
        end else if (state == SHIFT && cnt == CNT_W'(WIDTH - 1)) begin
            ovf_r <= (a_msb != b_msb) && (cell_d != a_msb);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            brw_r    <= 1'b0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (sub.start) begin
                        a_sr   <= sub.a;
                        b_sr   <= sub.b;
                        brw_r  <= 1'b0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result bits refill the minuend register from the top as its bits are consumed.
                    a_sr  <= {cell_d, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    brw_r <= cell_bout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        diff_r   <= {cell_d, a_sr[WIDTH-1:1]};
                        borrow_r <= cell_bout;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=8 operations plus an exhaustive WIDTH=2 sweep at full rate.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(2)) bus2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .sub(bus8));
    serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .sub(bus2));

    typedef struct packed {
        logic [7:0] d;
        logic       br;
        logic       ov;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    exp_t e8;
    exp_t e2;

    int n_checks   = 0;
    int n_pass     = 0;
    int dones2     = 0;
    int cyc2       = 0;
    int last_done2 = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Scoreboard monitors: pop the oldest expected result whenever a done pulse shows up.
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL dut8_spurious_done: got done=1 with no operation outstanding");
            end else begin
                e8 = q8.pop_front();
                chk("dut8_diff", 32'(bus8.diff), 32'(e8.d));
                chk("dut8_borrow", 32'(bus8.borrow), 32'(e8.br));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                chk("dut8_ovf", 32'(bus8.ovf), 32'(e8.ov));
`endif
            end
        end
    end

    always @(negedge clk) begin
        cyc2++;
        if (bus2.done === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                $display("FAIL dut2_spurious_done: got done=1 with no operation outstanding");
            end else begin
                e2 = q2.pop_front();
                chk("dut2_diff", 32'(bus2.diff), 32'(e2.d));
                chk("dut2_borrow", 32'(bus2.borrow), 32'(e2.br));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                chk("dut2_ovf", 32'(bus2.ovf), 32'(e2.ov));
`endif
                if (last_done2 >= 0) chk("dut2_done_period", 32'(cyc2 - last_done2), 32'd4);
            end
            last_done2 = cyc2;
            dones2++;
        end
    end

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                          input logic eb, input logic eo, input logic [7:0] hold, input bit poke);
        int lat;
        int nb;
        bit got;
        q8.push_back(exp_t'{d: ed, br: eb, ov: eo});
        @(posedge clk); #1;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = b ^ 8'h5A;
        lat = 0;
        nb  = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus8.busy === 1'b1) nb++;
            if (bus8.done === 1'b1) got = 1;
            if (lat == 4) chk("dut8_diff_hold", 32'(bus8.diff), 32'(hold));
            if (poke && lat == 3) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hFF;
                bus8.b     = 8'h00;
            end
            if (poke && lat == 4) bus8.start = 1'b0;
            if (poke && got) bus8.start = 1'b1;
        end
        chk("dut8_latency", 32'(lat), 32'd9);
        chk("dut8_busy_cycles", 32'(nb), 32'd8);
        if (poke) begin
            @(posedge clk); #1;
            bus8.start = 1'b0;
            @(negedge clk);
            chk("dut8_busy_after_ignored_start", 32'(bus8.busy), 32'd0);
        end
    endtask

    task automatic abort_op8();
        @(posedge clk); #1;
        bus8.start = 1'b1;
        bus8.a     = 8'hC3;
        bus8.b     = 8'h5A;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus8.busy), 32'd0);
        chk("abort_done", 32'(bus8.done), 32'd0);
        chk("abort_diff", 32'(bus8.diff), 32'd0);
        chk("abort_borrow", 32'(bus8.borrow), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("abort_ovf", 32'(bus8.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("dut8_busy_after_abort", 32'(bus8.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus2.start = 1'b0;
        bus2.a     = '0;
        bus2.b     = '0;
        @(negedge clk);
        chk("reset_busy", 32'(bus8.busy), 32'd0);
        chk("reset_done", 32'(bus8.done), 32'd0);
        chk("reset_diff", 32'(bus8.diff), 32'd0);
        chk("reset_borrow", 32'(bus8.borrow), 32'd0);
        chk("reset_dut2_busy", 32'(bus2.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op8(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 8'h00, 1'b0);
        do_op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 8'h1E, 1'b0);
        do_op8(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
        do_op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 8'h00, 1'b0);
        do_op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b0);
        do_op8(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 8'h80, 1'b1);
        abort_op8();
        do_op8(8'h12, 8'h34, 8'hDE, 1'b1, 1'b0, 8'h00, 1'b0);

        // Exhaustive 2-bit sweep with start held high so each op is accepted as soon as idle.
        @(posedge clk); #1;
        bus2.start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] pa;
            logic [1:0] pb;
            logic [1:0] pd;
            pa = 2'(i >> 2);
            pb = 2'(i);
            pd = pa - pb;
            q2.push_back(exp_t'{d: {6'b0, pd}, br: (pa < pb), ov: (pa[1] != pb[1]) && (pd[1] != pa[1])});
            bus2.a = pa;
            bus2.b = pb;
            @(posedge clk); #1;
            if (i == 15) bus2.start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        for (int t = 0; t < 20 && dones2 < 16; t++) @(negedge clk);
        chk("dut2_done_count", 32'(dones2), 32'd16);
        chk("dut8_scoreboard_drained", 32'(q8.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
